// File: rtl/cmp_stim_checker.sv
// Self-test stimulus generator and checker for a 1-bit magnitude comparator.
// Define CMP_CHK_STOP_ON_FAIL_EN to end a pass at its first mismatch.
module cmp_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       E,
  input  logic       G,
  input  logic       L,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [1:0] fail_idx
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [1:0] fidx_q, fidx_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d;

  logic [2:0] exp_resp;
  logic       mismatch;
  logic       stop;

  // The comparator sees the registered operands, so expectations derive from them.
  assign exp_resp = {a_q == b_q, a_q & ~b_q, ~a_q & b_q};
  assign mismatch = ({E, G, L} != exp_resp);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
    stop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fidx_d  = 2'd0;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == HoldLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != 4'hf) begin
            err_d = err_q + 4'd1;
          end
          if (err_q == 4'd0) begin
            fidx_d = idx_q;
          end
`ifdef CMP_CHK_STOP_ON_FAIL_EN
          stop = 1'b1;
`endif
        end
        if (stop || idx_q == 2'd3) begin
          state_d = StDone;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = StDrive;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d == StDrive) || (state_d == StCheck);
    done_d = (state_d == StDone);
    a_d    = busy_d ? idx_d[1] : 1'b0;
    b_d    = busy_d ? idx_d[0] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fidx_q  <= 2'd0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_idx = fidx_q;

endmodule

// File: tb/tb_cmp_stim_checker.sv
// Directed bench for cmp_stim_checker: two instances (HOLD_CYCLES 2 and 1) each
// driving a comparator model with selectable stuck-at faults.
module tb_cmp_stim_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;  // 0: HOLD_CYCLES=2 instance, 1: HOLD_CYCLES=1 instance
  int   fmode = 0;   // 0: good, 1: G stuck at 0, 2: E/G/L stuck at 1

  always #5 clk = ~clk;

  logic a2, b2, e2, g2, l2, busy2, done2, pass2;
  logic a1, b1, e1, g1, l1, busy1, done1, pass1;
  logic [3:0] err2, err1;
  logic [1:0] fi2, fi1;

  function automatic logic [2:0] resp(input logic a, input logic b, input int m);
    logic [2:0] r;
    r = {a == b, a & ~b, ~a & b};
    if (m == 1) r[1] = 1'b0;
    if (m == 2) r = 3'b111;
    return r;
  endfunction

  always_comb {e2, g2, l2} = resp(a2, b2, fmode);
  always_comb {e1, g1, l1} = resp(a1, b1, fmode);

  cmp_stim_checker #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a2), .B(b2), .E(e2), .G(g2), .L(l2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_idx(fi2)
  );

  cmp_stim_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a1), .B(b1), .E(e1), .G(g1), .L(l1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_idx(fi1)
  );

  // {A, B, busy, done, pass, err_cnt, fail_idx}
  logic [10:0] st2, st1, st_cur;
  assign st2 = {a2, b2, busy2, done2, pass2, err2, fi2};
  assign st1 = {a1, b1, busy1, done1, pass1, err1, fi1};
  always_comb st_cur = sel ? st1 : st2;

  int done_cnt2 = 0;
  always @(negedge clk) if (done2) done_cnt2 <= done_cnt2 + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses start and follows the pass; returns done latency (-1 on timeout)
  // and whether A/B/busy tracked vectors 0..3 while running.
  task automatic run_pass(input logic h1, output int lat, output int ab_ok);
    int hp;
    hp = h1 ? 2 : 3;
    sel = h1;
    lat = -1;
    ab_ok = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (st_cur[7]) begin
        lat = j;
        break;
      end
      if (st_cur[10:9] != 2'(j / hp) || !st_cur[8]) ab_ok = 0;
      @(posedge clk); #1;
    end
  endtask

`ifdef CMP_CHK_STOP_ON_FAIL_EN
  localparam int StuckErr = 1, StuckLat2 = 3, GLat2 = 9, GLat1 = 6;
`else
  localparam int StuckErr = 4, StuckLat2 = 12, GLat2 = 12, GLat1 = 8;
`endif

  typedef struct {
    logic h1;
    int   mode;
    int   lat;
    int   err;
    int   fidx;
    int   pass;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    int lat, ab_ok, n0, first, second;

    tbl[0] = '{1'b0, 0, 12,        0,        0, 1};
    tbl[1] = '{1'b0, 1, GLat2,     1,        2, 0};
    tbl[2] = '{1'b0, 2, StuckLat2, StuckErr, 0, 0};
    tbl[3] = '{1'b0, 0, 12,        0,        0, 1};
    tbl[4] = '{1'b1, 0, 8,         0,        0, 1};
    tbl[5] = '{1'b1, 1, GLat1,     1,        2, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state_h2", int'(st2), 0);
    check("reset_state_h1", int'(st1), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      fmode = tbl[i].mode;
      run_pass(tbl[i].h1, lat, ab_ok);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_ab_seq", i), ab_ok, 1);
      check($sformatf("v%0d_err_cnt", i), int'(st_cur[5:2]), tbl[i].err);
      check($sformatf("v%0d_fail_idx", i), int'(st_cur[1:0]), tbl[i].fidx);
      check($sformatf("v%0d_pass", i), int'(st_cur[6]), tbl[i].pass);
      repeat (2) @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of the third vector.
    fmode = 0;
    sel = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    n0 = done_cnt2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(st2), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("no_done_after_abort", done_cnt2 - n0, 0);
    @(posedge clk); #1;
    run_pass(1'b0, lat, ab_ok);
    check("post_reset_latency", lat, 12);
    check("post_reset_ab_seq", ab_ok, 1);
    check("post_reset_pass", int'(pass2), 1);
    repeat (2) @(posedge clk);
    #1;

    // start re-pulsed while busy must be ignored.
    n0 = done_cnt2;
    start = 1'b1;
    @(posedge clk); #1;
    for (int j = 1; j < 20; j++) begin
      start = (j == 3 || j == 8);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("single_done_pulse", done_cnt2 - n0, 1);
    check("repulse_busy_idle", int'(busy2), 0);

    // start held high restarts a pass on every return to IDLE.
    first = -1;
    second = -1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 30; j++) begin
      if (done2 && first < 0) first = j;
      else if (done2 && second < 0) second = j;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_start_first_done", first, 12);
    check("held_start_second_done", second, 26);
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_stim_checker.md
CMP_STIM_CHECKER -- requirements
Module: cmp_stim_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: cycles each vector is driven before its response is checked; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  begins a test pass when sampled high in IDLE.
REQ-005 The block SHALL have port A  output  1  stimulus operand A to the 1-bit comparator under test.
REQ-006 The block SHALL have port B  output  1  stimulus operand B to the 1-bit comparator under test.
REQ-007 The block SHALL have port E  input  1  comparator A==B response.
REQ-008 The block SHALL have port G  input  1  comparator A>B response.
REQ-009 The block SHALL have port L  input  1  comparator A<B response.
REQ-010 The block SHALL have port busy  output  1  high in DRIVE and CHECK.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse at the end of a pass.
REQ-012 The block SHALL have port pass  output  1  high when the last completed pass had zero mismatches.
REQ-013 The block SHALL have port err_cnt  output  4  mismatch count for the current or last pass.
REQ-014 The block SHALL have port fail_idx  output  2  vector index {A,B} of the first mismatch in the pass.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DRIVE, CHECK and DONE.
REQ-016 Vector order SHALL be idx 0..3 with {A,B}=idx: 00, 01, 10, 11.
REQ-017 IDLE -> DRIVE on start=1: idx=0, hold counter=0, err_cnt=0 and fail_idx=0 are cleared in the same cycle; pass is left unchanged.
REQ-018 In DRIVE, A/B SHALL present the current idx, and the hold counter SHALL increment each cycle; DRIVE -> CHECK when the counter equals HOLD_CYCLES-1.
REQ-019 In CHECK, A/B SHALL stay stable, and {E,G,L} SHALL be compared to the expected value: E=(A==B), G=A&~B, L=~A&B.
REQ-020 On a mismatch, err_cnt SHALL increment and saturate at 15; fail_idx SHALL be loaded only on the first mismatch of the pass.
REQ-021 CHECK -> DRIVE with idx+1 and the counter cleared when idx<3; CHECK -> DONE when idx==3 (no wrap).
REQ-022 In DONE, done=1 for exactly one cycle, pass SHALL be loaded with (err_cnt==0, including the final check), and the FSM SHALL return to IDLE.
REQ-023 Latency: with start sampled at edge T, done SHALL be high in the cycle after edge T+4*(HOLD_CYCLES+1).
REQ-024 start SHALL be ignored while busy or in DONE; start held high continuously SHALL begin a new pass on each return to IDLE.
REQ-025 A and B SHALL be 0 in IDLE and DONE; all outputs SHALL be registered.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE with A=0, B=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, idx=0 and counter=0, regardless of clk.
REQ-027 Reset asserted mid-pass SHALL abort the pass immediately with no done pulse; the first edge after release SHALL be in IDLE.

Configuration
REQ-028 Macro CMP_CHK_STOP_ON_FAIL_EN SHALL control stop-on-fail: when defined, the first mismatch in CHECK SHALL go directly to DONE (err_cnt=1, pass=0) and the remaining vectors SHALL be skipped.
REQ-029 When CMP_CHK_STOP_ON_FAIL_EN is not defined, all four vectors SHALL always be checked.

Verification
REQ-030 Correct comparator, HOLD_CYCLES=2, start pulse -> A/B sequence 00,01,10,11 with 3 cycles each; done is high 12 cycles after the start edge; pass=1, err_cnt=0.
REQ-031 G stuck at 0 -> only vector 10 fails; err_cnt=1, fail_idx=2, pass=0.
REQ-032 E,G,L all stuck at 1 -> err_cnt=4, fail_idx=0, pass=0 (without macro); with the macro: done after the first check, err_cnt=1.
REQ-033 rst_n pulsed low during the third vector -> outputs are at reset values asynchronously, no done pulse; a following start runs a full clean pass.
REQ-034 start re-pulsed while busy -> ignored; exactly one done pulse; a second start after done runs a second pass, and err_cnt is cleared.
REQ-035 HOLD_CYCLES=1 -> each vector is driven 2 cycles; done is high 8 cycles after the start edge.
